// File: rtl/moving_avg_mc.sv
// -----------------------------------------------------------------------------
// moving_avg_mc
//
// Multi-channel N-sample moving-average (boxcar FIR) filter. Every channel
// keeps a circular window of its last N samples plus a full-precision running
// sum, so the output is the exact floor-average of the window with no
// per-sample pre-division loss. All channels share one write pointer and one
// fill counter because they always advance in lockstep.
//
// Parameters
//   DATA_W    signed sample width per channel (8..32)
//   LOG2_N    window depth N = 2**LOG2_N (1..8)
//   CHANNELS  number of independent channels (1..8)
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   clear      synchronous flush of the window state (bypass unaffected)
//   bypass     1 = pass input sample through with 1-cycle delay, 0 = average
//   in_valid   one sample per channel is presented this cycle
//   in_data    channel c at bits [c*DATA_W +: DATA_W], two's complement
//   out_valid  1-cycle pulse, out_data carries a new result
//   out_data   per-channel result, same packing as in_data; holds when idle
//   primed     window holds N real samples since the last rst/clear
// -----------------------------------------------------------------------------
module moving_avg_mc #(
    parameter int DATA_W   = 24,
    parameter int LOG2_N   = 4,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         bypass,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         primed
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;

    // Sample windows. Contents are only ever read once the window is full,
    // so these need no reset.
    logic signed [DATA_W-1:0] ram [CHANNELS][N];

    logic [LOG2_N-1:0]        wptr;
    logic [LOG2_N:0]          fill;
    logic signed [ACC_W-1:0]  acc        [CHANNELS];

    logic signed [ACC_W-1:0]  acc_next   [CHANNELS];
    logic signed [DATA_W-1:0] sample     [CHANNELS];
    logic signed [DATA_W-1:0] old_sample [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] result;
    logic                     window_full;
    logic                     accept;

    // fill saturates at exactly N = 2**LOG2_N, so its MSB is set only when
    // the window is full.
    assign window_full = fill[LOG2_N];
    assign primed      = window_full;

    // clear outranks in_valid: a sample arriving with clear is dropped.
    assign accept = in_valid && !clear;

    // Per-channel datapath. The sample leaving the window is read before the
    // same slot is overwritten, and counts as zero until the window has
    // filled. acc is wide enough that the add/subtract can never overflow,
    // and taking its upper DATA_W bits is an arithmetic shift by LOG2_N,
    // i.e. a floor division by N.
    always_comb begin
        result     = '0;
        sample     = '{default: '0};
        old_sample = '{default: '0};
        acc_next   = '{default: '0};
        for (int c = 0; c < CHANNELS; c++) begin
            sample[c]     = in_data[c*DATA_W +: DATA_W];
            old_sample[c] = window_full ? ram[c][wptr] : '0;
            acc_next[c]   = acc[c] + ACC_W'(sample[c]) - ACC_W'(old_sample[c]);
            result[c*DATA_W +: DATA_W] = bypass ? sample[c]
                                                : acc_next[c][ACC_W-1:LOG2_N];
        end
    end

    // Window control, running sums and the registered output stage. The
    // window keeps updating while bypass is set so that leaving bypass gives
    // a correct average straight away.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else if (clear) begin
            wptr      <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else if (in_valid) begin
            wptr      <= wptr + LOG2_N'(1);
            if (!window_full) begin
                fill <= fill + (LOG2_N+1)'(1);
            end
            out_valid <= 1'b1;
            out_data  <= result;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= acc_next[c];
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Sample storage write; the matching read of the same slot happens
    // combinationally above in the same cycle, so it sees the old value.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ram[c][wptr] <= sample[c];
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_mc.sv
// -----------------------------------------------------------------------------
// tb_moving_avg_mc
//
// Directed and randomized bench for moving_avg_mc with its default parameters
// (24-bit samples, 16-sample window, 2 channels). A reference model keeps the
// last 16 accepted samples of each channel in a queue and computes the floor
// of their sum divided by 16 directly.
// -----------------------------------------------------------------------------
module tb_moving_avg_mc;

    localparam int DATA_W   = 24;
    localparam int LOG2_N   = 4;
    localparam int CHANNELS = 2;
    localparam int N        = 16;

    logic                       clk;
    logic                       rst;
    logic                       clear;
    logic                       bypass;
    logic                       in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic                       out_valid;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       primed;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model state
    longint win0[$];
    longint win1[$];
    logic          exp_valid;
    logic          exp_primed;
    logic [DATA_W-1:0] exp_d0;
    logic [DATA_W-1:0] exp_d1;

    moving_avg_mc #(
        .DATA_W  (DATA_W),
        .LOG2_N  (LOG2_N),
        .CHANNELS(CHANNELS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bypass   (bypass),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .primed   (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor division by the window length, rounding toward minus infinity.
    function automatic longint floorDivN(input longint s);
        longint q;
        q = s / N;
        if ((s % N != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint sumQ0();
        longint s = 0;
        foreach (win0[i]) s += win0[i];
        return s;
    endfunction

    function automatic longint sumQ1();
        longint s = 0;
        foreach (win1[i]) s += win1[i];
        return s;
    endfunction

    // Update the model with what the DUT saw at the last rising edge.
    task automatic modelStep(input logic v, input longint x0, input longint x1,
                             input logic byp, input logic clr, input logic r);
        longint a0;
        longint a1;
        if (r) begin
            win0.delete();
            win1.delete();
            exp_valid = 1'b0;
            exp_d0    = '0;
            exp_d1    = '0;
        end else if (clr) begin
            win0.delete();
            win1.delete();
            exp_valid = 1'b0;
        end else if (v) begin
            win0.push_back(x0);
            win1.push_back(x1);
            if (win0.size() > N) void'(win0.pop_front());
            if (win1.size() > N) void'(win1.pop_front());
            a0 = byp ? x0 : floorDivN(sumQ0());
            a1 = byp ? x1 : floorDivN(sumQ1());
            exp_d0    = a0[DATA_W-1:0];
            exp_d1    = a1[DATA_W-1:0];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        exp_primed = (win0.size() == N);
    endtask

    task automatic checkOutput(input string tag);
        n_asserts++;
        assert (out_valid === exp_valid) else begin
            n_fails++;
            $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
        end
        n_asserts++;
        assert (primed === exp_primed) else begin
            n_fails++;
            $error("[TB] FAIL %s primed observed=%b expected=%b", tag, primed, exp_primed);
        end
        n_asserts++;
        assert (out_data[DATA_W-1:0] === exp_d0) else begin
            n_fails++;
            $error("[TB] FAIL %s ch0 observed=%0d expected=%0d", tag,
                   $signed(out_data[DATA_W-1:0]), $signed(exp_d0));
        end
        n_asserts++;
        assert (out_data[2*DATA_W-1:DATA_W] === exp_d1) else begin
            n_fails++;
            $error("[TB] FAIL %s ch1 observed=%0d expected=%0d", tag,
                   $signed(out_data[2*DATA_W-1:DATA_W]), $signed(exp_d1));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare #1 later.
    task automatic applyStimulus(input logic v, input longint x0, input longint x1,
                                 input logic byp, input logic clr, input logic r,
                                 input string tag);
        in_valid = v;
        bypass   = byp;
        clear    = clr;
        rst      = r;
        in_data  = {x1[DATA_W-1:0], x0[DATA_W-1:0]};
        @(posedge clk);
        #1;
        modelStep(v, x0, x1, byp, clr, r);
        checkOutput(tag);
    endtask

    task automatic checkConst(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] req);
        n_asserts++;
        assert (obs === req) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(req));
        end
    endtask

    initial begin
        logic   v;
        logic   byp;
        logic   clr;
        longint r0;
        longint r1;
        int     acc_cnt;
        logic [4:0] gap_pat;

        rst = 1'b1; clear = 1'b0; bypass = 1'b0; in_valid = 1'b0; in_data = '0;
        exp_valid = 1'b0; exp_primed = 1'b0; exp_d0 = '0; exp_d1 = '0;
        $display("[TB] start");

        // Reset state
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "reset0");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "reset1");
        checkConst("reset_data", out_data[DATA_W-1:0], '0);

        // Constant input ramp-up and steady state
        applyStimulus(1'b1, 3000, -3000, 1'b0, 1'b0, 1'b0, "const");
        checkConst("const_first_ch0", out_data[DATA_W-1:0], 24'd187);
        checkConst("const_first_ch1", out_data[2*DATA_W-1:DATA_W], 24'hFFFF44);
        for (int i = 1; i < 40; i++) applyStimulus(1'b1, 3000, -3000, 1'b0, 1'b0, 1'b0, "const");
        checkConst("const_steady_ch0", out_data[DATA_W-1:0], 24'd3000);

        // Full scale, no wrap
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_fs");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 64'sh7FFFFF, -8388608, 1'b0, 1'b0, 1'b0, "fullscale");
        checkConst("fullscale_ch0", out_data[DATA_W-1:0], 24'h7FFFFF);
        checkConst("fullscale_ch1", out_data[2*DATA_W-1:DATA_W], 24'h800000);

        // Step after priming: exercises old-sample subtraction and pointer wrap
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_step");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1000, -1000, 1'b0, 1'b0, 1'b0, "step_pre");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1600, -1600, 1'b0, 1'b0, 1'b0, "step_post");
        checkConst("step_final", out_data[DATA_W-1:0], 24'd1600);

        // Gapped ramp with bypass over accepted samples 20..24
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_gap");
        gap_pat = 5'b01101;
        acc_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            v   = gap_pat[i % 5];
            byp = (acc_cnt >= 20) && (acc_cnt < 25);
            applyStimulus(v, 3000 + 40 * acc_cnt, -(3000 + 40 * acc_cnt), byp, 1'b0, 1'b0, "gap");
            if (v) acc_cnt++;
        end

        // Clear with a sample at sample 10, then rst mid-stream
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "rst_clr");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 500 + i, -500 - i, 1'b0, 1'b0, 1'b0, "pre_clear");
        applyStimulus(1'b1, 777, -777, 1'b0, 1'b1, 1'b0, "clear");
        applyStimulus(1'b1, 1234, -1234, 1'b0, 1'b0, 1'b0, "post_clear");
        checkConst("post_clear_ch1", out_data[2*DATA_W-1:DATA_W], 24'hFFFFB2);
        applyStimulus(1'b1, 999, -999, 1'b0, 1'b0, 1'b1, "rst_mid");
        checkConst("rst_mid_ch0", out_data[DATA_W-1:0], '0);

        // Randomized traffic with occasional clear
        for (int i = 0; i < 300; i++) begin
            r0  = longint'($signed(DATA_W'($urandom)));
            r1  = longint'($signed(DATA_W'($urandom)));
            v   = ($urandom_range(0, 3) != 0);
            byp = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 31) == 0);
            applyStimulus(v, r0, r1, byp, clr, 1'b0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
